// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receiver signal bundle: raw pin inputs toward the receiver and decoded
// key events / status back to the consumer.
interface ps2_scancode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       frame_error;
    logic       busy;

    modport slave (
        input  ps2_clk, ps2_data,
        output key_valid, key_code, key_extended, key_release, frame_error, busy
    );

    modport master (
        output ps2_clk, ps2_data,
        input  key_valid, key_code, key_extended, key_release, frame_error, busy
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard front end: pin conditioning, 11-bit frame receiver with timeout,
// and a Set-2 prefix folder (E0 / F0 / E1 pause) producing single key events.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic             clk,
    input  logic             reset,
    ps2_scancode_rx_if.slave bus
);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_PAUSE_SKIP
    } state_t;

    logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic              r_filt_clk;
    logic [7:0]        r_filt_cnt;
    logic [3:0]        r_bit_cnt;
    logic [9:0]        r_shift;
    logic [IDLE_W-1:0] r_idle_cnt;

    state_t            r_state, w_state_nxt;
    logic              r_ext, r_rel, w_ext_nxt, w_rel_nxt;
    logic [2:0]        r_skip, w_skip_nxt;
    logic              r_key_valid, w_key_valid_nxt;
    logic [7:0]        r_key_code, w_key_code_nxt;
    logic              r_key_ext, w_key_ext_nxt;
    logic              r_key_rel, w_key_rel_nxt;
    logic              r_frame_err, w_frame_err_nxt;

    logic              w_differs, w_flip, w_fall, w_last_bit, w_frame_ok;
    logic              w_byte_valid, w_timeout, w_frame_err;
    logic [7:0]        w_byte;

    // Idle-high pins: synchronizers reset to 1 so reset release never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (!w_differs) begin
                r_filt_cnt <= '0;
            end else if (w_flip) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 8'd1;
            end
        end
    end

    assign w_differs = (r_clk_s2 != r_filt_clk);
    assign w_flip    = w_differs && (r_filt_cnt == 8'(FILTER_LEN - 1));
    assign w_fall    = w_flip && r_filt_clk;

    // r_shift holds start, data[7:0], parity; the stop bit is checked live.
    assign w_last_bit   = w_fall && (r_bit_cnt == 4'd10);
    assign w_frame_ok   = !r_shift[0] && r_dat_s2 && (^r_shift[9:1]);
    assign w_byte       = r_shift[8:1];
    assign w_byte_valid = w_last_bit && w_frame_ok;
    assign w_timeout    = (r_bit_cnt != 4'd0) && !w_fall &&
                          (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign w_frame_err  = (w_last_bit && !w_frame_ok) || w_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_idle_cnt <= '0;
        end else if (w_fall) begin
            r_idle_cnt <= '0;
            if (w_last_bit) begin
                r_bit_cnt <= '0;
            end else begin
                r_shift[r_bit_cnt] <= r_dat_s2;
                r_bit_cnt          <= r_bit_cnt + 4'd1;
            end
        end else if (w_timeout || (r_bit_cnt == 4'd0)) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_skip      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_key_ext   <= 1'b0;
            r_key_rel   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ext       <= w_ext_nxt;
            r_rel       <= w_rel_nxt;
            r_skip      <= w_skip_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_ext   <= w_key_ext_nxt;
            r_key_rel   <= w_key_rel_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ext_nxt       = r_ext;
        w_rel_nxt       = r_rel;
        w_skip_nxt      = r_skip;
        w_key_valid_nxt = 1'b0;
        w_key_code_nxt  = r_key_code;
        w_key_ext_nxt   = r_key_ext;
        w_key_rel_nxt   = r_key_rel;
        w_frame_err_nxt = 1'b0;
        if (w_frame_err) begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
            w_ext_nxt       = 1'b0;
            w_rel_nxt       = 1'b0;
            w_skip_nxt      = '0;
        end else if (w_byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == 8'hE0) begin
                        w_ext_nxt = 1'b1;
                    end else if (w_byte == 8'hF0) begin
                        w_rel_nxt = 1'b1;
                    end else if (w_byte == 8'hE1) begin
                        w_state_nxt = ST_PAUSE_SKIP;
                        w_skip_nxt  = 3'd7;
                    end else begin
                        w_key_valid_nxt = 1'b1;
                        w_key_code_nxt  = w_byte;
                        w_key_ext_nxt   = r_ext;
                        w_key_rel_nxt   = r_rel;
                        w_ext_nxt       = 1'b0;
                        w_rel_nxt       = 1'b0;
                    end
                end
                ST_PAUSE_SKIP: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_key_valid_nxt = 1'b1;
                        w_key_code_nxt  = 8'hE1;
                        w_key_ext_nxt   = 1'b0;
                        w_key_rel_nxt   = 1'b0;
                        w_state_nxt     = ST_IDLE;
                        w_ext_nxt       = 1'b0;
                        w_rel_nxt       = 1'b0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.key_valid    = r_key_valid;
    assign bus.key_code     = r_key_code;
    assign bus.key_extended = r_key_ext;
    assign bus.key_release  = r_key_rel;
    assign bus.frame_error  = r_frame_err;
    assign bus.busy         = (r_bit_cnt != 4'd0);
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: stimulus queues expected events, a
// monitor pops and compares on every key_valid / frame_error pulse.
module tb_ps2_scancode_rx;
    localparam int unsigned FL   = 8;
    localparam int unsigned TO   = 200;
    localparam int unsigned HALF = 20;

    typedef struct {
        logic        is_err;
        logic [7:0]  code;
        logic        ext;
        logic        rel;
        int unsigned at_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_x;
    logic        clk = 1'b0;
    logic        reset;
    logic        busy_seen;
    int unsigned cyc = 0;
    int unsigned last_fall = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_key(input logic [7:0] c, input logic e, input logic r);
        exp_t x;
        x.is_err = 1'b0; x.code = c; x.ext = e; x.rel = r; x.at_cyc = 0;
        sb.push_back(x);
    endtask

    task automatic expect_err(input int unsigned at);
        exp_t x;
        x.is_err = 1'b1; x.code = 8'h00; x.ext = 1'b0; x.rel = 1'b0; x.at_cyc = at;
        sb.push_back(x);
    endtask

    // Frame bits: start 0, data LSB first, odd parity (optionally flipped), stop 1.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int unsigned nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            last_fall   = cyc;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) continue;
            if (bus.key_valid === 1'b1 || bus.frame_error === 1'b1) begin
                chk("valid_err_exclusive", {31'd0, bus.key_valid & bus.frame_error}, 32'd0);
                chk("busy_low_at_event", {31'd0, bus.busy}, 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: key_valid=%b frame_error=%b code=%02h, nothing expected (cycle %0d)",
                             bus.key_valid, bus.frame_error, bus.key_code, cyc);
                end else begin
                    mon_x = sb.pop_front();
                    chk("event_kind_is_err", {31'd0, bus.frame_error}, {31'd0, mon_x.is_err});
                    if (!mon_x.is_err) begin
                        chk("key_code", {24'd0, bus.key_code}, {24'd0, mon_x.code});
                        chk("key_extended", {31'd0, bus.key_extended}, {31'd0, mon_x.ext});
                        chk("key_release", {31'd0, bus.key_release}, {31'd0, mon_x.rel});
                    end else if (mon_x.at_cyc != 0) begin
                        chk("timeout_cycle", cyc, mon_x.at_cyc);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d events still expected", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_key_valid", {31'd0, bus.key_valid}, 32'd0);
        chk("rst_key_code", {24'd0, bus.key_code}, 32'd0);
        chk("rst_key_extended", {31'd0, bus.key_extended}, 32'd0);
        chk("rst_key_release", {31'd0, bus.key_release}, 32'd0);
        chk("rst_frame_error", {31'd0, bus.frame_error}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Clean make
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11);

        // Extended break, then plain make
        expect_key(8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h75, 1'b0, 11);
        expect_key(8'h1D, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 11);

        // Parity error clears the pending break prefix
        send_frame(8'hF0, 1'b0, 11);
        expect_err(0);
        send_frame(8'h1D, 1'b1, 11);
        expect_key(8'h1D, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 11);

        // Pass-through and idempotent prefixes
        expect_key(8'hFA, 1'b0, 1'b0);
        send_frame(8'hFA, 1'b0, 11);
        expect_key(8'h74, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h74, 1'b0, 11);

        // Glitches shorter than the filter
        busy_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ps2_clk = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.busy !== 1'b0) busy_seen = 1'b1;
            end
            bus.ps2_clk = 1'b1;
            repeat (15) begin
                @(negedge clk);
                if (bus.busy !== 1'b0) busy_seen = 1'b1;
            end
        end
        chk("glitch_busy", {31'd0, busy_seen}, 32'd0);

        // Partial frame then silence: error TO cycles after the 5th sample
        send_frame(8'h5A, 1'b0, 5);
        chk("busy_partial", {31'd0, bus.busy}, 32'd1);
        expect_err(last_fall + 2 + FL + TO);
        repeat (TO + 40) @(negedge clk);
        chk("busy_after_timeout", {31'd0, bus.busy}, 32'd0);
        expect_key(8'h23, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 11);

        // Pause sequence folds into one E1 event
        expect_key(8'hE1, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 11);
        send_frame(8'h14, 1'b0, 11);
        send_frame(8'h77, 1'b0, 11);
        send_frame(8'hE1, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h14, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h77, 1'b0, 11);

        // Reset mid-frame is silent; next frame decodes normally
        send_frame(8'h33, 1'b0, 5);
        chk("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_key_valid", {31'd0, bus.key_valid}, 32'd0);
        chk("midrst_key_code", {24'd0, bus.key_code}, 32'd0);
        chk("midrst_key_extended", {31'd0, bus.key_extended}, 32'd0);
        chk("midrst_key_release", {31'd0, bus.key_release}, 32'd0);
        chk("midrst_frame_error", {31'd0, bus.frame_error}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (TO + 40) @(negedge clk);
        expect_key(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 11);

        repeat (100) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
